// File: rtl/strrecog_frame_ctrl.sv
// Frame controller for a bit-serial string recognizer.
// Bytes in over valid/ready, shifted MSB-first, matched against a pattern.
module strrecog_frame_ctrl #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PAT_MAX-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [7:0]         r_byte;
  logic               r_last;
  logic [2:0]         r_idx;
  logic [PAT_MAX-1:0] r_hist;
  logic [LEN_W-1:0]   r_seen;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_len_ok;
  logic               w_start_ok;
  logic               w_start_bad;
  logic               w_accept;
  logic               w_shift;
  logic               w_bit;
  logic [PAT_MAX-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_seen_inc;
  logic [PAT_MAX-1:0] w_mask;
  logic               w_hit;
  logic               w_cnt_full;

  assign w_len_ok = (cfg_len != '0) &&
                    (cfg_len <= LEN_W'(PAT_MAX));

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_start_ok  = 1'b1;
            w_state_nxt = S_LOAD;
          end else begin
            w_start_bad = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy    = 1'b1;
        w_shift = 1'b1;
        if (r_idx == 3'd0) begin
          w_state_nxt = r_last ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_bit      = r_byte[r_idx];
  assign w_hist_nxt = {r_hist[PAT_MAX-2:0], w_bit};
  assign w_seen_inc = (r_seen == LEN_W'(PAT_MAX)) ?
                      r_seen : r_seen + 1'b1;
  assign w_cnt_full = &r_cnt;

  // Window mask selecting the low cfg_len history bits.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_hit = w_shift &&
                 (((w_hist_nxt ^ r_pat) & w_mask) == '0) &&
                 (w_seen_inc >= r_len);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Configuration is frozen at an accepted start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pat <= '0;
      r_len <= '0;
      r_ovl <= 1'b0;
    end else if (w_start_ok) begin
      r_pat <= cfg_pattern;
      r_len <= cfg_len;
      r_ovl <= cfg_overlap;
    end
  end

  // Byte capture and MSB-first bit index.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_byte <= '0;
      r_last <= 1'b0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_byte <= in_data;
      r_last <= in_last;
      r_idx  <= 3'd7;
    end else if (w_shift) begin
      r_idx  <= r_idx - 3'd1;
    end
  end

  // History persists across bytes; only a new frame clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (w_start_ok) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (w_shift) begin
      r_hist <= w_hist_nxt;
      r_seen <= (w_hit && !r_ovl) ? '0 : w_seen_inc;
    end
  end

  // Registered match pulse with saturating per-frame count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_match <= w_hit;
      if (w_start_ok || w_start_bad) begin
        r_cnt <= '0;
      end else if (w_hit && !w_cnt_full) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Sticky config error, refreshed on every start seen in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_start_bad) begin
      r_err <= 1'b1;
    end
  end

  assign match_pulse = r_match;
  assign match_count = r_cnt;
  assign cfg_err     = r_err;

endmodule

// File: tb/tb_strrecog_frame_ctrl.sv
// Bench for strrecog_frame_ctrl: vector table, reset abort,
// and random frames against a bit-stream reference model.
module tb_strrecog_frame_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;

  logic       in_ready, match_pulse, busy, done, cfg_err;
  logic [7:0] match_count;
  logic       s_ready, s_pulse, s_busy, s_done, s_err;
  logic [1:0] s_count;

  always #5 clk = ~clk;

  strrecog_frame_ctrl u_dut (
    .clk(clk), .resetn(resetn),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .match_pulse(match_pulse),
    .match_count(match_count), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  strrecog_frame_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .resetn(resetn),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(s_ready), .match_pulse(s_pulse),
    .match_count(s_count), .busy(s_busy), .done(s_done),
    .cfg_err(s_err)
  );

  int tot = 0;
  int errs = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pulse positions by bit number, handshakes, done pulses.
  int          cyc = 0;
  int          mon_bits = 0;
  int          mon_done = 0;
  int          mon_rdy = 0;
  int          mon_last_rdy = 0;
  int          mon_rdy_gap = 0;
  int          sat_pulses = 0;
  logic [15:0] mon_mask = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (match_pulse && mon_bits >= 1 && mon_bits <= 16)
      mon_mask[mon_bits-1] <= 1'b1;
    if (done) mon_done <= mon_done + 1;
    if (s_pulse) sat_pulses <= sat_pulses + 1;
    if (in_ready) begin
      mon_rdy      <= mon_rdy + 1;
      mon_rdy_gap  <= cyc - mon_last_rdy;
      mon_last_rdy <= cyc;
    end
    if (busy && !in_ready) mon_bits <= mon_bits + 1;
  end

  task automatic mon_clear();
    mon_bits     <= 0;
    mon_done     <= 0;
    mon_rdy      <= 0;
    mon_last_rdy <= 0;
    mon_rdy_gap  <= 0;
    sat_pulses   <= 0;
    mon_mask     <= '0;
  endtask

  // Reference: walk the frame's bit stream, compare trailing window.
  function automatic logic [15:0] model(input logic [7:0] pat,
                                        input int len,
                                        input bit ovl,
                                        input logic [15:0] strm,
                                        input int n);
    logic [15:0] m;
    int seen;
    bit ok;
    m = '0;
    seen = 0;
    for (int b = 0; b < 8 * n; b++) begin
      seen++;
      if (seen >= len) begin
        ok = 1;
        for (int k = 0; k < len; k++)
          if (strm[15-(b-len+1+k)] !== pat[len-1-k]) ok = 0;
        if (ok) begin
          m[b] = 1'b1;
          if (!ovl) seen = 0;
        end
      end
    end
    return m;
  endfunction

  task automatic run_frame(input logic [7:0] pat,
                           input logic [3:0] len,
                           input bit ovl,
                           input int n,
                           input logic [15:0] strm,
                           input bit rnd,
                           output bit first_done,
                           output int bits_at_done,
                           output bit to);
    bit got, seen;
    to = 0;
    bits_at_done = -1;
    mon_clear();
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_done = done;
    if (rnd) begin
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom);
      cfg_overlap = 1'($urandom);
    end
    if (len >= 1 && len <= 8) begin
      for (int i = 0; i < n; i++) begin
        if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = (i == 0) ? strm[15:8] : strm[7:0];
        in_last  = (i == n - 1);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
          if (in_ready) got = 1;
          @(negedge clk);
        end
        if (!got) to = 1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
      end
    end
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (done) begin
        seen = 1;
        bits_at_done = mon_bits;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) to = 1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    bit          ovl;
    int          n;
    logic [15:0] strm;
    logic [15:0] mask;
    int          cnt;
    bit          err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fd, to;
    int bad;
    int sat_exp;
    logic [15:0] em;
    logic [7:0] rp;
    logic [3:0] rl;
    bit ro;
    int rn;
    logic [15:0] rs;
    bit rerr;
    bit got;

    tbl[0] = '{8'h0A, 4'd4, 1'b1, 1, 16'hAA00, 16'h00A8, 3, 1'b0};
    tbl[1] = '{8'h0A, 4'd4, 1'b0, 1, 16'hAA00, 16'h0088, 2, 1'b0};
    tbl[2] = '{8'h06, 4'd4, 1'b1, 2, 16'h0300, 16'h0100, 1, 1'b0};
    tbl[3] = '{8'h01, 4'd1, 1'b1, 1, 16'hFF00, 16'h00FF, 8, 1'b0};
    tbl[4] = '{8'h0A, 4'd0, 1'b1, 1, 16'hAA00, 16'h0000, 0, 1'b1};
    tbl[5] = '{8'h0A, 4'd9, 1'b1, 1, 16'hAA00, 16'h0000, 0, 1'b1};

    #1;
    chk("reset_outputs",
        {in_ready, match_pulse, match_count, busy, done, cfg_err},
        '0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].n,
                tbl[i].strm, 1'b0, fd, bad, to);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_count", i), match_count, tbl[i].cnt);
      chk($sformatf("v%0d_err", i), cfg_err, tbl[i].err);
      chk($sformatf("v%0d_mask", i), mon_mask, tbl[i].mask);
      chk($sformatf("v%0d_done_cnt", i), mon_done, 1);
      chk($sformatf("v%0d_early_done", i), fd, tbl[i].err);
      chk($sformatf("v%0d_bits_at_done", i), bad,
          tbl[i].err ? 0 : 8 * tbl[i].n);
      chk($sformatf("v%0d_ready_cycles", i), mon_rdy,
          tbl[i].err ? 0 : tbl[i].n);
      sat_exp = (tbl[i].cnt > 3) ? 3 : tbl[i].cnt;
      chk($sformatf("v%0d_sat_count", i), s_count, sat_exp);
      chk($sformatf("v%0d_sat_pulses", i), sat_pulses, tbl[i].cnt);
      if (tbl[i].n == 2 && !tbl[i].err)
        chk($sformatf("v%0d_ready_gap", i), mon_rdy_gap, 9);
    end

    // Reset during SHIFT of the first byte aborts with no done.
    mon_clear();
    cfg_pattern = 8'h0A;
    cfg_len     = 4'd4;
    cfg_overlap = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (in_ready) got = 1;
      @(negedge clk);
    end
    chk("rst_accept", got, 1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_count", match_count, 1);
    chk("rst_pre_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_outputs",
        {in_ready, match_pulse, match_count, busy, done, cfg_err},
        '0);
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", mon_done, 0);
    run_frame(8'h0A, 4'd4, 1'b1, 1, 16'hAA00, 1'b0, fd, bad, to);
    chk("rst_after_timeout", to, 0);
    chk("rst_after_count", match_count, 3);
    chk("rst_after_mask", mon_mask, 16'h00A8);

    // Random frames with input gaps and cfg churn mid-frame.
    for (int i = 0; i < 30; i++) begin
      rp = 8'($urandom);
      rl = 4'($urandom_range(0, 9));
      ro = 1'($urandom);
      rn = $urandom_range(1, 2);
      rs = 16'($urandom);
      rerr = (rl < 1 || rl > 8);
      em = rerr ? 16'h0 : model(rp, int'(rl), ro, rs, rn);
      run_frame(rp, rl, ro, rn, rs, 1'b1, fd, bad, to);
      chk($sformatf("r%0d_timeout", i), to, 0);
      chk($sformatf("r%0d_err", i), cfg_err, rerr);
      chk($sformatf("r%0d_mask", i), mon_mask, em);
      chk($sformatf("r%0d_count", i), match_count, $countones(em));
      sat_exp = ($countones(em) > 3) ? 3 : $countones(em);
      chk($sformatf("r%0d_sat_count", i), s_count, sat_exp);
      chk($sformatf("r%0d_done_cnt", i), mon_done, 1);
      chk($sformatf("r%0d_bits_at_done", i), bad,
          rerr ? 0 : 8 * rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             tot, errs);
    $finish;
  end

endmodule
